spawn_request_scheduler: RTL

- Downstream consumer of the random tick generator's randomTick1/randomTick2 level outputs.
- Samples both ticks once per game tick, after the LFSR/comparator pipeline has settled, and accumulates per-lane pending spawn counts.
- Issues one spawn at a time to the enemy draw/update FSM over a req/ack handshake.
- Enforces a cooldown, measured in game ticks, between spawns.

---
 rtl/spawn_request_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spawn_request_scheduler.sv
// spawn_request_scheduler: turns sampled random ticks into paced, one-at-a-time spawn requests.
// Optional cooldown ramp enabled by defining SPAWN_DIFFICULTY_RAMP_EN.
module spawn_request_scheduler #(
  parameter int SAMPLE_DELAY   = 2,
  parameter int MAX_PENDING    = 7,
  parameter int COOLDOWN_TICKS = 4,
  parameter int MIN_COOLDOWN   = 1,
  parameter int RAMP_INTERVAL  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       gameTick,
  input  logic       randomTick1,
  input  logic       randomTick2,
  input  logic       clearSpawns,
  input  logic       spawnAck,
  output logic       spawnRequest,
  output logic       spawnLane,
  output logic [2:0] pendingCount1,
  output logic [2:0] pendingCount2,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, REQUEST, COOLDOWN} state_t;
  localparam logic [2:0] MAXP = 3'(MAX_PENDING);
  localparam logic [7:0] CDT  = 8'(COOLDOWN_TICKS);

  if (SAMPLE_DELAY < 1 || RAMP_INTERVAL < 1 || MIN_COOLDOWN < 0) begin : g_bad_params
    $error("spawn_request_scheduler: illegal parameter values");
  end

  state_t                  state_q, state_d;
  logic [SAMPLE_DELAY-1:0] dly_q, dly_d;
  logic [1:0][2:0]         pend_q, pend_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              cd_q, cd_d, eff_cd;
  logic                    lane_q, lane_d, last_q, last_d;
  logic                    strobe, ack, sat;
  logic [1:0]              inc, dec, busy, full;

  assign strobe = dly_q[SAMPLE_DELAY-1];
  assign ack    = (state_q == REQUEST) && spawnAck;

  always_comb begin
    dly_d = (dly_q << 1) | SAMPLE_DELAY'(gameTick);
    inc   = {2{strobe}} & {randomTick2, randomTick1};
    dec   = {2{ack}} & {lane_q, ~lane_q};
    busy  = {pend_q[1] != 3'd0, pend_q[0] != 3'd0};
    full  = {pend_q[1] == MAXP, pend_q[0] == MAXP};
    for (int i = 0; i < 2; i++)
      pend_d[i] = (full[i] && inc[i] && !dec[i]) ? pend_q[i] : pend_q[i] - 3'(dec[i]) + 3'(inc[i]);
    // a simultaneous ack makes room, so only an unmatched increment at saturation is a drop
    sat   = |(full & inc & ~dec);
    ovf_d = ovf_q | sat;
    cd_d  = ack ? eff_cd : (gameTick && cd_q != 8'd0) ? cd_q - 8'd1 : cd_q;
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    last_d  = last_q;
    case (state_q)
      IDLE:
        if (cd_q == 8'd0 && |busy) begin
          state_d = REQUEST;
          lane_d  = (busy == 2'b11) ? ~last_q : busy[1];
        end
      REQUEST:
        if (spawnAck) begin
          state_d = (eff_cd == 8'd0) ? IDLE : COOLDOWN;
          last_d  = lane_q;
        end
      COOLDOWN: state_d = (cd_q == 8'd0) ? IDLE : COOLDOWN;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      dly_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      cd_q    <= 8'd0;
      lane_q  <= 1'b0;
      last_q  <= 1'b1;
    end else if (clearSpawns) begin
      state_q <= IDLE;
      dly_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      cd_q    <= 8'd0;
      lane_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cd_q    <= cd_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end

`ifdef SPAWN_DIFFICULTY_RAMP_EN
  logic [7:0]  eff_q, eff_d;
  logic [15:0] acks_q, acks_d;
  logic        wrap;
  always_comb begin
    wrap   = acks_q == 16'(RAMP_INTERVAL - 1);
    acks_d = ack ? (wrap ? 16'd0 : acks_q + 16'd1) : acks_q;
    eff_d  = (ack && wrap && eff_q > 8'(MIN_COOLDOWN)) ? eff_q - 8'd1 : eff_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      eff_q  <= CDT;
      acks_q <= 16'd0;
    end else if (clearSpawns) begin
      eff_q  <= CDT;
      acks_q <= 16'd0;
    end else begin
      eff_q  <= eff_d;
      acks_q <= acks_d;
    end
  assign eff_cd = eff_q;
`else
  assign eff_cd = CDT;
`endif

  assign spawnRequest  = state_q == REQUEST;
  assign spawnLane     = lane_q;
  assign pendingCount1 = pend_q[0];
  assign pendingCount2 = pend_q[1];
  assign overflow      = ovf_q;
endmodule
